// File: rtl/mem_access_pkg.sv
// Shared size codes, state encodings and request bundle for the data memory initiator.
// Misalignment trapping is built only with MEM_ACCESS_MISALIGN_TRAP_EN.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_CAP  = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  typedef struct packed {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] data;
  } req_t;

  // Size code 2'b11 behaves as a word access.
  function automatic logic is_word(input logic [1:0] s);
    return s[1];
  endfunction

  function automatic logic misaligned_addr(
    input logic [1:0] s,
    input logic [1:0] o
  );
    logic r;
    r = 1'b0;
    if (is_word(s))
      r = (o != 2'b00);
    else if (s == SIZE_HALF)
      r = o[0];
    return r;
  endfunction

endpackage

// File: rtl/mem_access_controller_lane.sv
// Big-endian lane extraction/extension for loads and lane merge for stores.
// Halves select on offset[1] only; words ignore the offset.
module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        unsigned_load,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] merged
);

  logic [4:0]  shamt;
  logic [7:0]  bval;
  logic [15:0] hval;
  logic [31:0] bmask;

  // Byte at offset o sits at bit 8*(3-o); 3-o is ~o in two bits.
  assign shamt = {~offset, 3'b000};
  assign bval  = 8'(word >> shamt);
  assign hval  = offset[1] ? word[15:0] : word[31:16];
  assign bmask = 32'h0000_00ff << shamt;

  always_comb begin
    load_value = word;
    merged     = store_data;
    unique case (1'b1)
      is_word(size): begin
        load_value = word;
        merged     = store_data;
      end
      size == SIZE_HALF: begin
        load_value = unsigned_load ? {16'h0, hval}
                                   : {{16{hval[15]}}, hval};
        merged = offset[1] ? {word[31:16], store_data[15:0]}
                           : {store_data[15:0], word[15:0]};
      end
      default: begin
        load_value = unsigned_load ? {24'h0, bval}
                                   : {{24{bval[7]}}, bval};
        merged = (word & ~bmask)
               | ({24'h0, store_data[7:0]} << shamt);
      end
    endcase
  end

endmodule

// File: rtl/mem_access_controller.sv
// Load/store initiator for a word-wide big-endian data memory (RMW sub-word stores).
// Define MEM_ACCESS_MISALIGN_TRAP_EN to complete misaligned requests as faults.
module mem_access_controller
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  isStore,
  input  logic [1:0]            size,
  input  logic                  unsignedLoad,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           storeData,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           loadData,
  output logic                  misaligned,
  output logic [ADDR_WIDTH-1:0] memAddress,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [31:0]           memWordOut,
  input  logic [31:0]           memWordIn
);

  logic [1:0]  state;
  logic [1:0]  offset_q;
  req_t        rq;
  logic        fault;
  logic [31:0] lane_load;
  logic [31:0] lane_merge;

  byte_lane_unit u_lane (
    .word          (memWordIn),
    .offset        (offset_q),
    .size          (rq.size),
    .unsigned_load (rq.uns),
    .store_data    (rq.data),
    .load_value    (lane_load),
    .merged        (lane_merge)
  );

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign fault = misaligned_addr(size, addr[1:0]);
`else
  assign fault = 1'b0;
`endif

  assign busy     = (state != ST_IDLE);
  // Strobes are masked by reset so the memory never acts on a reset edge.
  assign memRead  = (state == ST_RD) && !reset;
  assign memWrite = (state == ST_WR) && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      done       <= 1'b0;
      misaligned <= 1'b0;
      loadData   <= '0;
      memAddress <= '0;
      memWordOut <= '0;
      offset_q   <= '0;
      rq         <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            rq.store   <= isStore;
            rq.size    <= size;
            rq.uns     <= unsignedLoad;
            rq.data    <= storeData;
            offset_q   <= addr[1:0];
            memAddress <= {addr[ADDR_WIDTH-1:2], 2'b00};
            if (fault) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else if (isStore && is_word(size)) begin
              memWordOut <= storeData;
              state      <= ST_WR;
            end else begin
              state <= ST_RD;
            end
          end
        end
        ST_RD: state <= ST_CAP;
        ST_CAP: begin
          if (rq.store) begin
            memWordOut <= lane_merge;
            state      <= ST_WR;
          end else begin
            loadData <= lane_load;
            done     <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        ST_WR: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench: directed vector table, hand sequences and a random run
// checked against an arithmetic model of big-endian lane access.
module tb_mem_access_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        isStore;
  logic [1:0]  size;
  logic        unsignedLoad;
  logic [31:0] addr;
  logic [31:0] storeData;
  logic        busy;
  logic        done;
  logic [31:0] loadData;
  logic        misaligned;
  logic [31:0] memAddress;
  logic        memRead;
  logic        memWrite;
  logic [31:0] memWordOut;
  logic [31:0] memWordIn;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  always #5 clk = ~clk;

  mem_access_controller #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .isStore      (isStore),
    .size         (size),
    .unsignedLoad (unsignedLoad),
    .addr         (addr),
    .storeData    (storeData),
    .busy         (busy),
    .done         (done),
    .loadData     (loadData),
    .misaligned   (misaligned),
    .memAddress   (memAddress),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .memWordOut   (memWordOut),
    .memWordIn    (memWordIn)
  );

  // Memory with a registered read port.
  always @(posedge clk) begin
    if (memWrite) mem[memAddress[9:2]] <= memWordOut;
    if (memRead) memWordIn <= mem[memAddress[9:2]];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic m_mis(input int a, input int sz);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    return (sz == 1 && (a % 2) != 0) || (sz >= 2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input int a,
                                         input int sz, input bit u);
    int o;
    logic [31:0] v;
    o = a % 4;
    if (sz == 0) begin
      v = (w >> (8 * (3 - o))) & 32'hff;
      if (!u && v[7]) v = v | 32'hffff_ff00;
    end else if (sz == 1) begin
      v = (w >> ((o >= 2) ? 0 : 16)) & 32'hffff;
      if (!u && v[15]) v = v | 32'hffff_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input int a,
                                          input int sz, input logic [31:0] d);
    int sh;
    logic [31:0] m;
    if (sz == 0) begin
      sh = 8 * (3 - (a % 4));
      m  = 32'hff << sh;
      return (w & ~m) | ((d & 32'hff) << sh);
    end else if (sz == 1) begin
      sh = ((a % 4) >= 2) ? 0 : 16;
      m  = 32'hffff << sh;
      return (w & ~m) | ((d & 32'hffff) << sh);
    end
    return d;
  endfunction

  task automatic do_op(input bit st, input int sz, input bit u, input int a,
                       input logic [31:0] sd, output logic [31:0] ld,
                       output int lat, output logic mis, output int rd,
                       output int wr, output logic [31:0] wout,
                       output logic [31:0] waddr);
    @(negedge clk);
    req = 1'b1; isStore = st; size = 2'(sz);
    unsignedLoad = u; addr = a; storeData = sd;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1; rd = 0; wr = 0; wout = 'x; waddr = 'x;
    while (!done && lat < 12) begin
      rd += int'(memRead);
      if (memWrite) begin
        wr++; wout = memWordOut; waddr = memAddress;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = 99;
    ld = loadData; mis = misaligned;
  endtask

  typedef struct {
    bit          st;
    int          sz;
    bit          u;
    int          a;
    logic [31:0] sd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [31:0] ld, wout, waddr;
    int lat, rd, wr, sz, a;
    logic mis;
    bit st, u;
    logic [31:0] sd, w;

    for (int i = 0; i < 256; i++) begin
      mem[i] = 32'h0; ref_mem[i] = 32'h0;
    end
    memWordIn = 32'h0;
    req = 0; isStore = 0; size = 0; unsignedLoad = 0;
    addr = 0; storeData = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mis", 32'(misaligned), 0);
    chk("rst_rd", 32'(memRead), 0);
    chk("rst_wr", 32'(memWrite), 0);
    chk("rst_ld", loadData, 0);
    chk("rst_maddr", memAddress, 0);
    chk("rst_wout", memWordOut, 0);
    reset = 1'b0;

    vt[0] = '{1, 2, 0, 400, 32'hA1B2C3D4, 32'hA1B2C3D4, 2};
    vt[1] = '{0, 2, 0, 400, 32'h0, 32'hA1B2C3D4, 3};
    vt[2] = '{0, 0, 0, 401, 32'h0, 32'hFFFFFFB2, 3};
    vt[3] = '{0, 0, 1, 401, 32'h0, 32'h000000B2, 3};
    vt[4] = '{0, 1, 1, 402, 32'h0, 32'h0000C3D4, 3};
    vt[5] = '{1, 0, 0, 403, 32'h0000005A, 32'hA1B2C35A, 4};
    vt[6] = '{0, 2, 0, 400, 32'h0, 32'hA1B2C35A, 3};
    vt[7] = '{0, 1, 0, 402, 32'h0, 32'hFFFFC35A, 3};
    vt[8] = '{0, 0, 0, 400, 32'h0, 32'hFFFFFFA1, 3};

    for (int i = 0; i < 9; i++) begin
      do_op(vt[i].st, vt[i].sz, vt[i].u, vt[i].a, vt[i].sd,
            ld, lat, mis, rd, wr, wout, waddr);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_mis", i), 32'(mis), 0);
      chk($sformatf("v%0d_wr", i), 32'(wr), vt[i].st ? 1 : 0);
      chk($sformatf("v%0d_rd", i), 32'(rd),
          (vt[i].st && vt[i].sz >= 2) ? 0 : 1);
      if (vt[i].st) begin
        chk($sformatf("v%0d_wout", i), wout, vt[i].exp);
        chk($sformatf("v%0d_waddr", i), waddr, 400);
      end else begin
        chk($sformatf("v%0d_ld", i), ld, vt[i].exp);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_pulse", i), 32'(done), 0);
    end

    // sh then lh with req held through the done cycle
    @(negedge clk);
    req = 1; isStore = 1; size = 2'b01; unsignedLoad = 0;
    addr = 400; storeData = 32'h0000_1234;
    @(posedge clk); #1;
    isStore = 0;
    lat = 1;
    while (!done && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b_sh_lat", 32'(lat), 4);
    @(posedge clk); #1;
    chk("b2b_accept", 32'(busy), 1);
    req = 0;
    lat = 0;
    while (!done && lat < 12) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b_lh_lat", 32'(lat), 2);
    chk("b2b_lh_ld", loadData, 32'h0000_1234);

    do_op(0, 2, 0, 402, 0, ld, lat, mis, rd, wr, wout, waddr);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    chk("mis_lat", 32'(lat), 1);
    chk("mis_flag", 32'(mis), 1);
    chk("mis_rdwr", 32'(rd + wr), 0);
`else
    chk("nomis_lat", 32'(lat), 3);
    chk("nomis_flag", 32'(mis), 0);
    chk("nomis_ld", ld, 32'h1234C35A);
`endif
    do_op(0, 2, 0, 400, 0, ld, lat, mis, rd, wr, wout, waddr);
    chk("mis_after_ld", ld, 32'h1234C35A);

    // reset during the WR cycle of sb @400
    @(negedge clk);
    req = 1; isStore = 1; size = 2'b00; addr = 400; storeData = 32'hEE;
    @(posedge clk); #1;
    req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rstwr_wr_before", 32'(memWrite), 1);
    reset = 1;
    #1;
    chk("rstwr_wr_gated", 32'(memWrite), 0);
    @(posedge clk); #1;
    chk("rstwr_busy", 32'(busy), 0);
    chk("rstwr_done", 32'(done), 0);
    reset = 0;
    do_op(0, 2, 0, 400, 0, ld, lat, mis, rd, wr, wout, waddr);
    chk("rstwr_ld", ld, 32'h1234C35A);

    // random traffic in words 0..7, untouched above
    for (int n = 0; n < 200; n++) begin
      st = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 3);
      u  = 1'($urandom_range(0, 1));
      a  = $urandom_range(0, 31);
      sd = $urandom;
      do_op(st, sz, u, a, sd, ld, lat, mis, rd, wr, wout, waddr);
      w = ref_mem[a / 4];
      chk($sformatf("r%0d_mis", n), 32'(mis), 32'(m_mis(a, sz)));
      if (m_mis(a, sz)) begin
        chk($sformatf("r%0d_lat", n), 32'(lat), 1);
        chk($sformatf("r%0d_rdwr", n), 32'(rd + wr), 0);
      end else if (st) begin
        ref_mem[a / 4] = m_store(w, a, sz, sd);
        chk($sformatf("r%0d_lat", n), 32'(lat), (sz >= 2) ? 2 : 4);
        chk($sformatf("r%0d_wout", n), wout, ref_mem[a / 4]);
        chk($sformatf("r%0d_waddr", n), waddr, 32'((a / 4) * 4));
      end else begin
        chk($sformatf("r%0d_lat", n), 32'(lat), 3);
        chk($sformatf("r%0d_ld", n), ld, m_load(w, a, sz, u));
      end
    end
    for (int i = 0; i < 8; i++)
      chk($sformatf("final_w%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
